// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave receiver: FSM encodings and the
// overflow counter type.
package spi_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam int OVF_W = 8;
  typedef logic [OVF_W-1:0] ovf_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, followed by an edge
// detector that compares the last two synchronized samples.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic [STAGES-1:0] sync_next;
  logic              prev_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sync_next[gi] = din;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= {STAGES{RESET_VAL}};
      prev_reg <= RESET_VAL;
    end else begin
      sync_reg <= sync_next;
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = sync_reg[STAGES-1] & ~prev_reg;
  assign fall  = ~sync_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: deserializes MSB-first words and pushes them to
// a downstream FIFO with an active-low write strobe.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  input  logic                  FULL,
  output logic                  WE,
  output logic [DATA_WIDTH-1:0] SPI_data,
  output logic                  rx_busy,
  output logic                  frame_err,
  output ovf_t                  ovf_count
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic unused_edges;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_edges = sclk_level ^ sclk_fall ^ mosi_rise ^ mosi_fall;

  logic [1:0]            state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  ovf_t                  ovf_reg, ovf_next;
  logic                  ferr_reg, ferr_next;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  complete;

  assign shifted  = {shift_reg[DATA_WIDTH-2:0], mosi_level};
  assign complete = sclk_rise && (cnt_reg == LAST_CNT);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    ovf_next   = ovf_reg;
    ferr_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cs_fall) begin
          state_next = ST_SHIFT;
          cnt_next   = '0;
          shift_next = '0;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          shift_next = shifted;
          cnt_next   = cnt_reg + 1'b1;
        end
        // A completing edge wins over a simultaneous cs_n rise: the word is
        // delivered (or dropped) and WRITE then falls back to IDLE.
        if (complete) begin
          cnt_next  = '0;
          data_next = shifted;
          if (!FULL) begin
            state_next = ST_WRITE;
          end else begin
            if (ovf_reg != '1) ovf_next = ovf_reg + 1'b1;
            if (cs_rise) state_next = ST_IDLE;
          end
        end else if (cs_rise) begin
          state_next = ST_IDLE;
          ferr_next  = (cnt_next != '0);
        end
      end
      ST_WRITE: begin
        state_next = cs_level ? ST_IDLE : ST_SHIFT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      ovf_reg   <= '0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      ovf_reg   <= ovf_next;
      ferr_reg  <= ferr_next;
    end
  end

  assign WE        = (state_reg != ST_WRITE);
  assign SPI_data  = data_reg;
  assign rx_busy   = ~cs_level;
  assign frame_err = ferr_reg;
  assign ovf_count = ovf_reg;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: mode-0 frames at clk/8, checking FIFO
// writes, overflow counting, truncated frames and reset behaviour.
module tb_spi_slave_rx;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sclk = 1'b0;
  logic         cs_n = 1'b1;
  logic         mosi = 1'b0;
  logic         FULL = 1'b0;
  logic         WE;
  logic [W-1:0] SPI_data;
  logic         rx_busy;
  logic         frame_err;
  logic [7:0]   ovf_count;

  int total = 0;
  int bad   = 0;

  int   we_cnt = 0, we_long = 0, fe_cnt = 0, fe_long = 0;
  logic we_prev = 1'b0, fe_prev = 1'b0;
  logic [W-1:0] wq[$];
  int   w0, f0;

  always #5 clk = ~clk;

  spi_slave_rx #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .FULL(FULL),
    .WE(WE), .SPI_data(SPI_data), .rx_busy(rx_busy), .frame_err(frame_err),
    .ovf_count(ovf_count)
  );

  // Record every write strobe and error pulse, and any that last over one clk.
  always @(negedge clk) begin
    if (rst) begin
      if (!WE) begin
        we_cnt++;
        wq.push_back(SPI_data);
        if (we_prev) we_long++;
      end
      if (frame_err) begin
        fe_cnt++;
        if (fe_prev) fe_long++;
      end
    end
    we_prev = rst && !WE;
    fe_prev = rst && frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [31:0] word_at(input int idx);
    if (idx < wq.size()) return {16'h0, wq[idx]};
    return 32'hxxxxxxxx;
  endfunction

  task automatic bit_out(input logic b);
    mosi = b;
    #40;
    sclk = 1'b1;
    #40;
    sclk = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] d, input int nbits);
    for (int i = 0; i < nbits; i++) bit_out(d[W-1-i]);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #80;
    cs_n = 1'b1;
    #120;
  endtask

  task automatic mark();
    w0 = we_cnt;
    f0 = fe_cnt;
    wq.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_we", WE, 1);
    chk("rst_data", SPI_data, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", ovf_count, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Single word
    mark();
    cs_low();
    chk("busy_low", rx_busy, 1);
    send_word(16'hA55A, 16);
    cs_high();
    chk("a55a_we", we_cnt - w0, 1);
    chk("a55a_data", word_at(0), 16'hA55A);
    chk("a55a_ferr", fe_cnt - f0, 0);
    chk("a55a_ovf", ovf_count, 0);
    chk("busy_high", rx_busy, 0);

    // Back-to-back words in one frame
    mark();
    cs_low();
    send_word(16'h1234, 16);
    send_word(16'hBEEF, 16);
    cs_high();
    chk("b2b_we", we_cnt - w0, 2);
    chk("b2b_data0", word_at(0), 16'h1234);
    chk("b2b_data1", word_at(1), 16'hBEEF);
    chk("b2b_hold", SPI_data, 16'hBEEF);

    // FIFO full: words dropped and counted, saturating at 255
    mark();
    FULL = 1'b1;
    cs_low();
    for (int i = 0; i < 3; i++) send_word(16'h5A00 + 16'(i), 16);
    cs_high();
    chk("full_we", we_cnt - w0, 0);
    chk("full_ovf3", ovf_count, 3);
    cs_low();
    for (int i = 0; i < 252; i++) send_word(16'h0F0F, 16);
    cs_high();
    chk("full_ovf255", ovf_count, 255);
    cs_low();
    for (int i = 0; i < 45; i++) send_word(16'hF0F0, 16);
    cs_high();
    chk("full_sat", ovf_count, 255);
    chk("full_we_all", we_cnt - w0, 0);
    FULL = 1'b0;

    // Truncated frame, then a good one
    mark();
    cs_low();
    send_word(16'hFFFF, 9);
    cs_high();
    chk("trunc_ferr", fe_cnt - f0, 1);
    chk("trunc_we", we_cnt - w0, 0);
    mark();
    cs_low();
    send_word(16'h00FF, 16);
    cs_high();
    chk("after_trunc_we", we_cnt - w0, 1);
    chk("after_trunc_data", word_at(0), 16'h00FF);
    chk("after_trunc_ferr", fe_cnt - f0, 0);

    // Reset mid-frame
    mark();
    cs_low();
    send_word(16'hFFFF, 10);
    rst = 1'b0;
    #20;
    chk("midrst_we", WE, 1);
    chk("midrst_data", SPI_data, 0);
    chk("midrst_ovf", ovf_count, 0);
    cs_n = 1'b1;
    #40;
    rst = 1'b1;
    #80;
    cs_low();
    send_word(16'h8001, 16);
    cs_high();
    chk("midrst_we_cnt", we_cnt - w0, 1);
    chk("midrst_word", word_at(0), 16'h8001);
    chk("midrst_ferr", fe_cnt - f0, 0);

    // Last sclk edge and cs_n rise together
    mark();
    cs_low();
    send_word(16'hC3C3, 15);
    mosi = 1'b1;
    #40;
    sclk = 1'b1;
    cs_n = 1'b1;
    #40;
    sclk = 1'b0;
    #120;
    chk("same_we", we_cnt - w0, 1);
    chk("same_data", word_at(0), 16'hC3C3);
    chk("same_ferr", fe_cnt - f0, 0);
    chk("same_busy", rx_busy, 0);

    // sclk activity with cs_n high is ignored
    mark();
    send_word(16'hFFFF, 16);
    #120;
    chk("cs_high_we", we_cnt - w0, 0);
    chk("cs_high_ferr", fe_cnt - f0, 0);

    chk("we_width", we_long, 0);
    chk("ferr_width", fe_long, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SPI frame and FIFO word width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth for sclk, cs_n and mosi.
REQ-003 clk  input  1  system clock, single clock domain for all logic.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 sclk  input  1  external SPI clock, asynchronous to clk.
REQ-006 cs_n  input  1  external SPI chip select, active low.
REQ-007 mosi  input  1  external SPI serial data, MSB first.
REQ-008 FULL  input  1  downstream SPI FIFO full flag, active high.
REQ-009 WE  output  1  FIFO write enable, active low, one-clk pulse per accepted word.
REQ-010 SPI_data  output  DATA_WIDTH  FIFO write data, valid whenever WE is low.
REQ-011 rx_busy  output  1  high while synchronized cs_n is low.
REQ-012 frame_err  output  1  one-clk pulse on a truncated frame.
REQ-013 ovf_count  output  8  count of words dropped because FULL was high, saturating.

Function
REQ-014 sclk, cs_n and mosi SHALL each pass through SYNC_STAGES flip-flops before use; edge detection SHALL compare the last two synchronized samples.
REQ-015 SPI mode SHALL be fixed CPOL=0, CPHA=0: mosi sampled on each synchronized sclk rising edge; supported sclk frequency SHALL be at most clk/8.
REQ-016 State machine SHALL have states IDLE, SHIFT, WRITE; reset state IDLE.
REQ-017 IDLE -> SHIFT on synchronized cs_n falling edge; bit counter and shift register cleared on that transition.
REQ-018 In SHIFT, each sclk rising edge SHALL shift mosi into bit 0 (MSB first) and increment the bit counter.
REQ-019 On the sclk edge completing bit DATA_WIDTH, the word SHALL be latched into SPI_data and the counter cleared; if FULL is low the FSM SHALL enter WRITE, else ovf_count SHALL increment (holding at 255) and the FSM stays in SHIFT.
REQ-020 WRITE SHALL drive WE low for exactly one clk, the cycle after the completing edge, then return to SHIFT if cs_n low, else IDLE.
REQ-021 SPI_data SHALL hold its value until the next completed word; WE SHALL be high in all other cycles.
REQ-022 Multiple words SHALL be received back to back within one cs_n low period.
REQ-023 Synchronized cs_n rising with bit counter non-zero SHALL discard the partial word, pulse frame_err for one clk, and go to IDLE.
REQ-024 cs_n rising with bit counter zero SHALL go to IDLE without frame_err.
REQ-025 Completing sclk edge and cs_n rising detected in the same clk: word completes normally (WRITE or drop), no frame_err, then IDLE.
REQ-026 sclk edges while cs_n high SHALL be ignored.
REQ-027 FULL SHALL be sampled only on the completing edge cycle; FULL rising during WRITE SHALL not cancel the pending WE pulse.

Reset
REQ-028 While rst low: WE=1, SPI_data=0, rx_busy=0, frame_err=0, ovf_count=0, FSM=IDLE, counters, shift register and synchronizers cleared (synchronizers to sclk=0, cs_n=1, mosi=0).
REQ-029 rst asserted mid-frame SHALL abandon the frame with no WE pulse; after release a new cs_n falling edge is required.

Structure
REQ-030 FSM state encodings and the ovf_count width SHALL live in a shared package spi_pkg.
REQ-031 Synchronizer plus edge detector SHALL be a sub-module sync_edge (per-signal instance, outputs level, rise, fall).

Verification
REQ-032 cs_n low, 16 bits 0xA55A at clk/8, FULL=0 -> one WE low pulse, SPI_data=0xA55A, frame_err=0, ovf_count=0.
REQ-033 One cs_n period with 0x1234 then 0xBEEF -> two WE pulses in order, SPI_data 0x1234 then 0xBEEF.
REQ-034 FULL=1 during 3 complete words -> no WE pulse, ovf_count=3; 300 such words -> ovf_count=255.
REQ-035 cs_n raised after 9 bits -> frame_err one-clk pulse, no WE; next full frame 0x00FF -> WE pulse with 0x00FF.
REQ-036 rst low after 10 bits of 0xFFFF, release, new frame 0x8001 -> WE only once, SPI_data=0x8001.
REQ-037 16th sclk edge and cs_n rising in same synchronized cycle with 0xC3C3 -> WE pulse with 0xC3C3, frame_err=0, FSM IDLE.
